des_job_queue: RTL and testbench
================================

Name: des_job_queue

Overview:
- Job sequencer between the AHB-Lite slave controller and triple_DES_block.
- Buffers 64-bit data blocks and their encrypt/decrypt mode in an input FIFO, and issues them one at a time to the DES core.
- Waits for the core's done, then stores each result in an output FIFO that the slave drains on AHB reads.
- Lets the bus master queue several blocks without polling the core between them.

Parameters:
- DEPTH, 4, entries per FIFO (input and output); power of 2, minimum 2.
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit; used only with DES_TIMEOUT_EN.

Ports:
- HCLK  in  1  system clock, all logic on rising edge.
- HRESET  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous flush: empties both FIFOs, aborts the job in flight, FSM to IDLE.
- in_push  in  1  slave writes one job.
- in_data  in  64  plaintext/ciphertext block.
- in_encr  in  1  1=encrypt, 0=decrypt.
- in_full  out  1  input FIFO full.
- out_pop  in  1  slave consumes the head result.
- out_data  out  64  head of output FIFO (first-word fall-through); 0 when empty.
- out_valid  out  1  output FIFO non-empty.
- in_count  out  $clog2(DEPTH)+1  input FIFO occupancy.
- out_count  out  $clog2(DEPTH)+1  output FIFO occupancy.
- busy  out  1  FSM not in IDLE.
- err_ovf  out  1  sticky: push rejected on full input FIFO.
- err_unf  out  1  sticky: pop requested on empty output FIFO.
- err_timeout  out  1  sticky watchdog flag (see Optional Feature).
- des_enable  out  1  one-cycle start pulse to the DES core.
- des_encr  out  1  mode to the DES core; held stable from LAUNCH through WAIT.
- des_data  out  64  block to the DES core; held stable from LAUNCH through WAIT.
- des_result  in  64  DES core output block.
- des_done  in  1  DES core completion, sampled only in WAIT.

Behaviour:
- Reset (async) and sclr: both FIFOs empty; all counts 0; FSM IDLE; all outputs 0; sticky flags cleared.
- Input FIFO push:
  - in_push with in_full=1 is dropped and sets err_ovf.
  - Fullness is judged before the same-cycle engine pop, so a push to a full FIFO is rejected even if the engine pops in that cycle.
- Output FIFO pop:
  - out_pop with out_valid=0 is ignored and sets err_unf.
  - Simultaneous engine push and out_pop on a non-empty FIFO leaves out_count unchanged.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE -> LAUNCH when input non-empty AND out_count < DEPTH. On this edge the input head is captured into des_data/des_encr and popped.
  - LAUNCH: des_enable=1 for exactly one cycle; -> WAIT.
  - WAIT: on des_done=1, des_result is pushed into the output FIFO; -> IDLE.
- Output overflow cannot occur: the launch check reserves the slot, and only the engine pushes.
- Throughput: 3 cycles of overhead per job plus DES latency; the next launch can occur the cycle after the return to IDLE.
- Ordering: results leave in the same order jobs entered.
- busy=1 in LAUNCH and WAIT.
- Pointers wrap modulo DEPTH. Counts range 0..DEPTH inclusive.
- sclr has priority over every other event in the same cycle.
- A des_done arriving after an sclr abort is ignored, because the FSM is already in IDLE.

Optional Feature:
- Macro: DES_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entering WAIT.
  - When it reaches TIMEOUT_CYCLES without des_done, err_timeout is set, the job is discarded (no output push), and the FSM returns to IDLE.
  - A des_done in the same cycle as expiry wins: the result is stored and the flag is not set.
- Not defined: no counter is built; err_timeout is tied to 0; WAIT waits indefinitely.

Test Plan:
- Single job. DES model with done after 10 cycles; push in_data=64'h0123456789ABCDEF, in_encr=1.
  - Expect exactly one des_enable pulse 2 cycles after the push, with des_data=64'h0123456789ABCDEF.
  - Expect out_valid=1 one cycle after done, out_data = model result, out_count=1.
- Ordering. Push 4 jobs 64'h1..64'h4 back-to-back with alternating encr.
  - Expect des_encr sequence 1,0,1,0.
  - After draining, out_data order matches results of 1..4.
  - in_full=1 after the 4th push if no launch has occurred yet.
- Backpressure. Fill the output FIFO to 4 with out_pop=0, then push a 5th job.
  - Expect no des_enable while out_count=4.
  - Pop once -> launch within 2 cycles.
- Overflow/underflow. Push 5 jobs into a full FIFO with the engine stalled -> err_ovf=1, in_count=4. Pop with out_valid=0 -> err_unf=1, counts unchanged.
- Flush. Assert sclr in WAIT.
  - Expect FSM IDLE, counts 0, flags 0.
  - A later des_done produces no output push.
  - Async HRESET deasserted mid-WAIT gives the same result.
- Timeout (DES_TIMEOUT_EN, TIMEOUT_CYCLES=16). DES model never asserts done.
  - Expect err_timeout=1 after 16 WAIT cycles, FSM IDLE, out_count=0, next queued job launched.

Source files
------------

// File: rtl/des_job_queue.sv
// des_job_queue: input/output job FIFOs that sequence 64-bit blocks through a triple-DES core
// Ports: HCLK clock, HRESET async active-low reset, sclr synchronous flush;
//   in_push/in_data/in_encr/in_full/in_count: job input FIFO;
//   out_pop/out_data/out_valid/out_count: result FIFO (fall-through, 0 when empty);
//   busy engine active, err_ovf/err_unf/err_timeout sticky error flags;
//   des_enable/des_encr/des_data to the core, des_result/des_done from the core.
// Optional: define DES_TIMEOUT_EN to build a TIMEOUT_CYCLES watchdog on the WAIT state.
module des_job_queue #(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    sclr,
  input  logic                    in_push,
  input  logic [63:0]             in_data,
  input  logic                    in_encr,
  output logic                    in_full,
  input  logic                    out_pop,
  output logic [63:0]             out_data,
  output logic                    out_valid,
  output logic [$clog2(DEPTH):0]  in_count,
  output logic [$clog2(DEPTH):0]  out_count,
  output logic                    busy,
  output logic                    err_ovf,
  output logic                    err_unf,
  output logic                    err_timeout,
  output logic                    des_enable,
  output logic                    des_encr,
  output logic [63:0]             des_data,
  input  logic [63:0]             des_result,
  input  logic                    des_done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  state_t state;
  logic [64:0] in_mem [DEPTH];
  logic [63:0] out_mem [DEPTH];
  logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
  logic push_ok, pop_ok, launch, done_ok, expire;
`ifdef DES_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  // a done in the expiry cycle wins over the watchdog
  assign expire = state == WAIT && !des_done && tmr == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif
  assign in_full = in_count == FULL;
  assign out_valid = out_count != '0;
  assign out_data = out_valid ? out_mem[out_rp] : '0;
  assign busy = state != IDLE;
  assign push_ok = in_push && !in_full;
  assign pop_ok = out_pop && out_valid;
  // launching only with a free output slot guarantees the result always fits
  assign launch = state == IDLE && in_count != '0 && out_count != FULL;
  assign done_ok = state == WAIT && des_done;
  always_ff @(posedge HCLK) begin
    if (push_ok) in_mem[in_wp] <= {in_encr, in_data};
    if (done_ok) out_mem[out_wp] <= des_result;
  end
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state <= IDLE;
      {in_wp, in_rp, out_wp, out_rp, in_count, out_count} <= '0;
      {err_ovf, err_unf, err_timeout, des_enable, des_encr} <= '0;
      des_data <= '0;
`ifdef DES_TIMEOUT_EN
      tmr <= '0;
`endif
    end else if (sclr) begin
      state <= IDLE;
      {in_wp, in_rp, out_wp, out_rp, in_count, out_count} <= '0;
      {err_ovf, err_unf, err_timeout, des_enable, des_encr} <= '0;
      des_data <= '0;
`ifdef DES_TIMEOUT_EN
      tmr <= '0;
`endif
    end else begin
      in_wp <= in_wp + AW'(push_ok);
      in_rp <= in_rp + AW'(launch);
      in_count <= in_count + (AW+1)'(push_ok) - (AW+1)'(launch);
      out_wp <= out_wp + AW'(done_ok);
      out_rp <= out_rp + AW'(pop_ok);
      out_count <= out_count + (AW+1)'(done_ok) - (AW+1)'(pop_ok);
      err_ovf <= err_ovf | (in_push & in_full);
      err_unf <= err_unf | (out_pop & ~out_valid);
      err_timeout <= err_timeout | expire;
      des_enable <= launch;
      if (launch) {des_encr, des_data} <= in_mem[in_rp];
      state <= launch ? LAUNCH : state == LAUNCH ? WAIT : (done_ok || expire) ? IDLE : state;
`ifdef DES_TIMEOUT_EN
      tmr <= state == WAIT ? tmr + TW'(1) : '0;
`endif
    end
  end
endmodule

// File: tb/tb_des_job_queue.sv
// tb_des_job_queue: vector, directed and randomized checks of des_job_queue against a queue-level model
module tb_des_job_queue;
  localparam int DEPTH = 4;
  localparam int TMO = 16;
  logic HCLK = 0, HRESET = 1, sclr = 0, in_push = 0, in_encr = 0, out_pop = 0;
  logic [63:0] in_data = '0;
  logic in_full, out_valid, busy, err_ovf, err_unf, err_timeout, des_enable, des_encr, des_done;
  logic [63:0] out_data, des_data, des_result;
  logic [2:0] in_count, out_count;
  logic man = 0, man_done = 0, rsp_done = 0;
  logic [63:0] man_result = '0, rsp_result = '0;
  int fixed_lat = 0;
  int errors = 0, checks = 0;
  assign des_done = man ? man_done : rsp_done;
  assign des_result = man ? man_result : rsp_result;
  des_job_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .sclr(sclr),
    .in_push(in_push), .in_data(in_data), .in_encr(in_encr), .in_full(in_full),
    .out_pop(out_pop), .out_data(out_data), .out_valid(out_valid),
    .in_count(in_count), .out_count(out_count), .busy(busy),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_timeout(err_timeout),
    .des_enable(des_enable), .des_encr(des_encr), .des_data(des_data),
    .des_result(des_result), .des_done(des_done)
  );
  always #5 HCLK = ~HCLK;
  function automatic logic [63:0] fn(input logic [63:0] d, input logic e);
    return e ? ({d[31:0], d[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0) : d + 64'h1357_9BDF_0246_8ACE;
  endfunction
  function automatic int lat_of(input logic [63:0] d);
    return fixed_lat > 0 ? fixed_lat : 1 + int'(d[1:0]);
  endfunction
  // DES core stand-in: done in the lat-th WAIT cycle after the enable pulse
  int rcnt = 0;
  logic rpend = 0, re = 0;
  logic [63:0] rd = '0;
  always @(negedge HCLK) begin
    rsp_done = 0;
    if (des_enable && !man) begin
      rpend = 1; rcnt = lat_of(des_data) - 1; rd = des_data; re = des_encr;
    end else if (rpend) begin
      if (rcnt == 0) begin rsp_done = 1; rsp_result = fn(rd, re); rpend = 0; end
      else rcnt--;
    end
  end
  task automatic tick();
    @(posedge HCLK); #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_out(input logic [63:0] d, input logic e);
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("drain_data", out_data, fn(d, e));
    out_pop = 1; tick(); out_pop = 0;
  endtask
  task automatic pulse_sclr();
    sclr = 1; tick(); sclr = 0;
  endtask
  typedef struct {
    logic push; logic [63:0] d; logic pop;
    int ic; int oc; logic bz; logic en; logic full; logic ovf; logic unf;
  } vec_t;
  typedef struct packed {logic [63:0] d; logic e;} job_t;
  job_t mq_in[$];
  logic [63:0] mq_out[$];
  job_t cur;
  int ph = 0, w = 0;
  logic m_ovf = 0, m_unf = 0;
  // queue-level model: ph 0 idle, 1 launching, 2 waiting for w-th cycle result
  task automatic model_step(input logic push, input job_t j, input logic pop);
    int pin = mq_in.size();
    int pout = mq_out.size();
    logic go = ph == 0 && pin > 0 && pout < DEPTH;
    logic dn = ph == 2 && w == lat_of(cur.d);
    if (push && pin == DEPTH) m_ovf = 1;
    if (pop && pout == 0) m_unf = 1;
    if (pop && pout > 0) void'(mq_out.pop_front());
    if (dn) mq_out.push_back(fn(cur.d, cur.e));
    if (go) cur = mq_in.pop_front();
    if (push && pin < DEPTH) mq_in.push_back(j);
    if (go) ph = 1;
    else if (ph == 1) begin ph = 2; w = 1; end
    else if (dn) ph = 0;
    else if (ph == 2) w++;
  endtask
  initial begin
    vec_t tv[8];
    logic enc_seen[$];
    int n, en_n;
    logic saw;
    logic [63:0] ld;
    #2 HRESET = 0;
    #20;
    chk("rst_in_count", in_count, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {err_ovf, err_unf, err_timeout, in_full, des_enable, des_encr}, 0);
    chk("rst_des_data", des_data, 0);
    @(negedge HCLK) HRESET = 1;
    tick();
    // single job, 10-cycle core
    fixed_lat = 10;
    in_push = 1; in_data = 64'h0123456789ABCDEF; in_encr = 1;
    tick(); in_push = 0;
    chk("t1_in_count", in_count, 1);
    chk("t1_no_enable_yet", des_enable, 0);
    tick();
    chk("t1_enable", des_enable, 1);
    chk("t1_des_data", des_data, 64'h0123456789ABCDEF);
    chk("t1_des_encr", des_encr, 1);
    n = 0; en_n = 0;
    while (!out_valid && n < 30) begin tick(); n++; en_n += int'(des_enable); end
    chk("t1_result_latency", n, 11);
    chk("t1_extra_enables", en_n, 0);
    chk("t1_out_data", out_data, fn(64'h0123456789ABCDEF, 1));
    chk("t1_out_count", out_count, 1);
    chk("t1_busy", busy, 0);
    out_pop = 1; tick(); out_pop = 0;
    chk("t1_popped_valid", out_valid, 0);
    chk("t1_popped_data", out_data, 0);
    // ordering: jobs 1..4 with alternating mode, results left in the output FIFO
    fixed_lat = 0;
    for (int c = 0; c < 80 && out_count != 3'd4; c++) begin
      in_push = c < 4; in_data = 64'(c + 1); in_encr = (c % 2) == 0;
      tick();
      if (des_enable) enc_seen.push_back(des_encr);
    end
    in_push = 0;
    chk("ord_launches", enc_seen.size(), 4);
    for (int i = 0; i < enc_seen.size(); i++) chk("ord_encr", enc_seen[i], (i % 2) == 0);
    // backpressure: output FIFO full, four more jobs must wait
    en_n = 0;
    for (int c = 0; c < 4; c++) begin
      in_push = 1; in_data = 64'(c + 5); in_encr = 1;
      tick();
      en_n += int'(des_enable);
    end
    in_push = 0;
    chk("bp_in_full", in_full, 1);
    chk("bp_in_count", in_count, 4);
    repeat (3) begin tick(); en_n += int'(des_enable); end
    chk("bp_no_launch", en_n, 0);
    chk("bp_out_count", out_count, 4);
    chk("bp_head", out_data, fn(64'h1, 1));
    out_pop = 1; tick(); out_pop = 0;
    saw = 0; ld = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (des_enable && !saw) begin saw = 1; ld = des_data; end
    end
    chk("bp_launch_after_pop", saw, 1);
    chk("bp_launch_data", ld, 64'h5);
    expect_out(64'h2, 0);
    expect_out(64'h3, 1);
    expect_out(64'h4, 0);
    for (int i = 5; i <= 8; i++) expect_out(64'(i), 1);
    // stalled engine: overflow and underflow vectors
    man = 1; man_done = 0;
    pulse_sclr();
    tv[0] = '{1, 64'h11, 0, 1, 0, 0, 0, 0, 0, 0};
    tv[1] = '{1, 64'h12, 0, 1, 0, 1, 1, 0, 0, 0};
    tv[2] = '{1, 64'h13, 0, 2, 0, 1, 0, 0, 0, 0};
    tv[3] = '{1, 64'h14, 0, 3, 0, 1, 0, 0, 0, 0};
    tv[4] = '{1, 64'h15, 0, 4, 0, 1, 0, 1, 0, 0};
    tv[5] = '{1, 64'h16, 0, 4, 0, 1, 0, 1, 1, 0};
    tv[6] = '{0, 64'h0, 1, 4, 0, 1, 0, 1, 1, 1};
    tv[7] = '{0, 64'h0, 0, 4, 0, 1, 0, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      in_push = tv[i].push; in_data = tv[i].d; in_encr = 0; out_pop = tv[i].pop;
      tick();
      in_push = 0; out_pop = 0;
      chk($sformatf("vec%0d_in_count", i), in_count, 64'(tv[i].ic));
      chk($sformatf("vec%0d_out_count", i), out_count, 64'(tv[i].oc));
      chk($sformatf("vec%0d_busy", i), busy, tv[i].bz);
      chk($sformatf("vec%0d_enable", i), des_enable, tv[i].en);
      chk($sformatf("vec%0d_full", i), in_full, tv[i].full);
      chk($sformatf("vec%0d_ovf", i), err_ovf, tv[i].ovf);
      chk($sformatf("vec%0d_unf", i), err_unf, tv[i].unf);
    end
    // flush in WAIT, then a stale done
    pulse_sclr();
    chk("fl_busy", busy, 0);
    chk("fl_counts", {in_count, out_count}, 0);
    chk("fl_flags", {err_ovf, err_unf, in_full}, 0);
    chk("fl_des_data", des_data, 0);
    man_result = 64'hDEAD; man_done = 1; tick(); man_done = 0; tick();
    chk("fl_stale_done", out_count, 0);
    chk("fl_stale_valid", out_valid, 0);
    // async reset in the middle of WAIT
    man = 0; fixed_lat = 10;
    in_push = 1; in_data = 64'hCAFE; in_encr = 1; tick(); in_push = 0;
    repeat (3) tick();
    chk("ar_busy_before", busy, 1);
    #2 HRESET = 0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_des_data", des_data, 0);
    @(negedge HCLK) HRESET = 1;
    repeat (15) tick();
    chk("ar_stale_done", out_count, 0);
    chk("ar_idle", busy, 0);
`ifdef DES_TIMEOUT_EN
    // watchdog: core never answers
    man = 1; man_done = 0;
    in_push = 1; in_data = 64'hA0; tick();
    in_data = 64'hB0; tick(); in_push = 0;
    chk("to_launch_a", des_data, 64'hA0);
    repeat (16) tick();
    chk("to_still_wait", busy, 1);
    chk("to_not_yet", err_timeout, 0);
    tick();
    chk("to_flag", err_timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_no_push", out_count, 0);
    tick();
    chk("to_next_launch", des_enable, 1);
    chk("to_next_data", des_data, 64'hB0);
`endif
    // randomized traffic against the queue model
    man = 0; fixed_lat = 0;
    pulse_sclr();
    repeat (6) tick();
    pulse_sclr();
    mq_in.delete(); mq_out.delete(); ph = 0; w = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 600; i++) begin
      job_t j;
      logic p, q;
      p = ($urandom % 2) == 0;
      q = $urandom_range(0, 99) < (i < 300 ? 20 : 60);
      j.d = {$urandom, $urandom}; j.e = $urandom % 2;
      in_push = p; in_data = j.d; in_encr = j.e; out_pop = q;
      tick();
      model_step(p, j, q);
      chk("rnd_in_count", in_count, 64'(mq_in.size()));
      chk("rnd_out_count", out_count, 64'(mq_out.size()));
      chk("rnd_out_data", out_data, mq_out.size() > 0 ? mq_out[0] : 64'h0);
      chk("rnd_busy", busy, ph != 0);
      chk("rnd_enable", des_enable, ph == 1);
      chk("rnd_flags", {err_ovf, err_unf}, {m_ovf, m_unf});
      if (ph == 1) chk("rnd_des_job", {des_data, des_encr}, {cur.d, cur.e});
    end
    in_push = 0; out_pop = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
